// File: rtl/jk_bank_ctrl.sv
// jk_bank_ctrl: command sequencer driving a WIDTH-bit JK flip-flop bank.
// Optional ROTL on op 7 when JK_BANK_CTRL_ROTATE_EN is defined.
module jk_bank_ctrl #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_data,
  input  logic [CNT_W-1:0] cmd_cnt,
  input  logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] j,
  output logic [WIDTH-1:0] k,
  output logic             busy,
  output logic             done,
  output logic             err
);

  typedef enum logic {IDLE, EXEC} state_t;

  localparam logic [2:0] OP_NOP = 3'd0;
  localparam logic [2:0] OP_LD  = 3'd1;
  localparam logic [2:0] OP_CLR = 3'd2;
  localparam logic [2:0] OP_SET = 3'd3;
  localparam logic [2:0] OP_TGL = 3'd4;
  localparam logic [2:0] OP_SHL = 3'd5;
  localparam logic [2:0] OP_SHR = 3'd6;
  localparam logic [2:0] OP_ROT = 3'd7;

  localparam logic [CNT_W-1:0] CNT_ONE =
    {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           state_q, state_d;
  logic [2:0]       op_q;
  logic [WIDTH-1:0] data_q;
  logic [CNT_W-1:0] cnt_q, cnt_ld;
  logic             done_d, err_d;
  logic             accept, op_legal, op_multi, last;
  logic [WIDTH-1:0] t;

  assign cmd_ready = (state_q == IDLE);
  assign busy      = (state_q == EXEC);
  assign last      = (cnt_q == CNT_ONE);

  // Opcode legality and run length of the incoming command
  always_comb begin
`ifdef JK_BANK_CTRL_ROTATE_EN
    op_legal = 1'b1;
    op_multi = (cmd_op == OP_SHL) || (cmd_op == OP_SHR)
            || (cmd_op == OP_ROT);
`else
    op_legal = (cmd_op != OP_ROT);
    op_multi = (cmd_op == OP_SHL) || (cmd_op == OP_SHR);
`endif
    cnt_ld = CNT_ONE;
    if (op_multi && (cmd_cnt != '0))
      cnt_ld = cmd_cnt;
  end

  // Next-state, accept and pulse generation
  always_comb begin
    state_d = state_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    accept  = 1'b0;
    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          if (op_legal) begin
            accept  = 1'b1;
            state_d = EXEC;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      EXEC: begin
        if (last) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, pulses and latched command
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      done    <= 1'b0;
      err     <= 1'b0;
      op_q    <= '0;
      data_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      done    <= done_d;
      err     <= err_d;
      if (accept) begin
        op_q   <= cmd_op;
        data_q <= cmd_data;
        cnt_q  <= cnt_ld;
      end else if (busy && !last) begin
        cnt_q <= cnt_q - CNT_ONE;
      end
    end
  end

  // Per-op J/K drive; bank holds outside EXEC
  always_comb begin
    j = '0;
    k = '0;
    t = '0;
    if (busy) begin
      case (op_q)
        OP_NOP: begin
          j = '0;
          k = '0;
        end
        OP_LD: begin
          j = data_q;
          k = ~data_q;
        end
        OP_CLR: begin
          j = '0;
          k = '1;
        end
        OP_SET: begin
          j = '1;
          k = '0;
        end
        OP_TGL: begin
          j = data_q;
          k = data_q;
        end
        OP_SHL: begin
          t = {q[WIDTH-2:0], data_q[0]};
          j = t;
          k = ~t;
        end
        OP_SHR: begin
          t = {data_q[0], q[WIDTH-1:1]};
          j = t;
          k = ~t;
        end
`ifdef JK_BANK_CTRL_ROTATE_EN
        OP_ROT: begin
          t = {q[WIDTH-2:0], q[WIDTH-1]};
          j = t;
          k = ~t;
        end
`endif
        default: begin
          j = '0;
          k = '0;
        end
      endcase
    end
  end

endmodule

// File: doc/jk_bank_ctrl.md
Name: jk_bank_ctrl

Overview:
- Command-driven controller that sequences a WIDTH-bit bank of JK flip-flops. It holds no data state of its own.
- Each cycle it drives per-bit J/K so the bank loads, clears, sets, toggles or shifts; it reads bank state back on q.
- Sits between a command source using a valid/ready handshake and the JK storage bank.
- Multi-bit shifts run over several cycles under an FSM.

Parameters:
WIDTH, 8, bank width in bits (>=2)
CNT_W, 4, width of shift-count field

Ports:
clk  input  1  rising-edge clock shared with the JK bank
rst  input  1  asynchronous, active-low reset
cmd_valid  input  1  command present
cmd_ready  output  1  controller can accept a command
cmd_op  input  3  opcode
cmd_data  input  WIDTH  load value / toggle mask / serial-in bit in [0]
cmd_cnt  input  CNT_W  shift count
q  input  WIDTH  current JK bank outputs
j  output  WIDTH  J drive to bank
k  output  WIDTH  K drive to bank
busy  output  1  command executing
done  output  1  one-cycle completion pulse
err  output  1  one-cycle illegal-opcode pulse

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, j=0, k=0 (bank holds), busy=0, done=0, err=0. Latched op/data/count are cleared.
- Reset mid-command aborts the command. The bank keeps whatever the last completed edge produced.
- FSM states: IDLE, EXEC.
- cmd_ready = (state==IDLE).
- Accept occurs on an edge where cmd_valid & cmd_ready. At accept: op, data and count are latched, and the FSM goes IDLE->EXEC.
- An illegal op is not accepted into EXEC. It pulses err for 1 cycle and stays in IDLE.
- In EXEC: busy=1. j/k are combinational from the latched op, latched data and live q. The bank updates at each edge while in EXEC.
- Per-op drive (q+ = value the bank takes at the edge):
  - 0 NOP: j=0, k=0.
  - 1 LOAD: j=data, k=~data.
  - 2 CLEAR: j=0, k=all-1.
  - 3 SET: j=all-1, k=0.
  - 4 TOGGLE: j=data, k=data (masked bits invert).
  - 5 SHL: t={q[WIDTH-2:0],sbit}; j=t, k=~t.
  - 6 SHR: t={sbit,q[WIDTH-1:1]}; j=t, k=~t.
  - 7: reserved (see optional feature).
  - sbit = latched data[0].
- Ops 0-4 stay in EXEC for exactly 1 cycle.
- Ops 5/6 stay in EXEC for max(cnt,1) cycles, tracked by an internal down-counter. cnt=0 is treated as 1. cnt=2^CNT_W-1 gives the maximum run.
- Leaving EXEC: next state IDLE and done=1 for one cycle. done is registered and coincides with cmd_ready=1.
- Back-to-back commands: a command may be accepted in the same cycle done is high. Its first update lands one edge later.
- Latency: accept edge E0 -> first bank update at E1 -> last update at En (n = 1, or max(cnt,1) for shifts) -> done high in the cycle after En.
- Outside EXEC: j=k=0 always.
- cmd_* inputs are ignored when cmd_ready=0.

Optional Feature:
- Macro: JK_BANK_CTRL_ROTATE_EN.
- Defined: op 7 = ROTL with t={q[WIDTH-2:0],q[WIDTH-1]}, j=t, k=~t. It is multi-cycle like SHL, lasts max(cnt,1) cycles, and ignores sbit.
- Undefined: op 7 is illegal -> err pulse, no accept, no bank change.

Test Plan:
- Reset: hold rst=0 mid-SHL with cnt=5, release -> j=k=0, busy=0, cmd_ready=1 immediately; bank unchanged after release until next command.
- LOAD 8'hA5 then TOGGLE 8'h0F, issued back-to-back on done -> q=A5 then q=AA; each done lasts exactly one cycle.
- CLEAR -> q=00. SET -> q=FF. NOP -> q unchanged, done still pulses.
- With q=81: SHL, cnt=3, data[0]=1 -> q after each edge 03,07,0F; busy for 3 cycles; done in the 4th cycle after accept.
- With q=80: SHR, cnt=0, data[0]=0 -> single shift, q=40, done after 1 EXEC cycle.
- Op 7, with and without the macro:
  - Defined: q=81, cnt=1 -> q=03.
  - Undefined: err=1 for 1 cycle, cmd_ready stays 1, q=81 unchanged.
